// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Holds the FSM state encoding, port ids, default depth and the address check.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEFAULT_DEPTH = 256;

  // An access is legal only when it is word aligned and inside the memory.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
    return (addr < limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  // Winner selection from the request pair and the last-granted pointer.
  always_comb begin
    win = M0;
    any = |req;
    case (req)
      2'b01:   win = M0;
      2'b10:   win = M1;
      2'b11: begin
        if (last == M0) begin
          win = M1;
        end else begin
          win = M0;
        end
      end
      default: win = M0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates CPU (m0) and DMA (m1) accesses onto one data-memory port,
// one access at a time through IDLE -> ACCESS -> RESP.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  state_t      state_r;
  state_t      state_next_s;

  logic        last_r;
  logic        id_r;
  logic        we_r;
  logic        ok_r;

  logic [1:0]  req_s;
  logic        win_s;
  logic        any_s;
  logic        start_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_ok_s;

  logic [1:0]  gnt_r;
  logic [1:0]  rvalid_r;
  logic [1:0]  err_r;
  logic [31:0] m0_rdata_r;
  logic [31:0] m1_rdata_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        mem_w_r;
  logic        mem_r_r;

  assign req_s = {m1_req, m0_req};

  rr_arb2 u_rr (
    .req  (req_s),
    .last (last_r),
    .win  (win_s),
    .any  (any_s)
  );

  // Requests are only looked at in IDLE; anything else is ignored, not queued.
  assign start_s = (state_r == IDLE) && any_s;

  // Mux the winning master's transaction fields.
  always_comb begin
    sel_we_s    = m0_we;
    sel_addr_s  = m0_addr;
    sel_wdata_s = m0_wdata;
    if (win_s == M1) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    sel_ok_s = addr_ok(sel_addr_s, ADDR_LIMIT);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transaction context and round-robin pointer; the pointer moves only on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= M1;
      id_r   <= M0;
      we_r   <= 1'b0;
      ok_r   <= 1'b0;
    end else if (start_s) begin
      last_r <= win_s;
      id_r   <= win_s;
      we_r   <= sel_we_s;
      ok_r   <= sel_ok_s;
    end else begin
      last_r <= last_r;
      id_r   <= id_r;
      we_r   <= we_r;
      ok_r   <= ok_r;
    end
  end

  // Registered outputs: strobes are set on the edge that enters ACCESS so they
  // are high for exactly the ACCESS cycle; responses likewise cover RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_r       <= 2'b00;
      rvalid_r    <= 2'b00;
      err_r       <= 2'b00;
      m0_rdata_r  <= 32'h0000_0000;
      m1_rdata_r  <= 32'h0000_0000;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_w_r     <= 1'b0;
      mem_r_r     <= 1'b0;
    end else begin
      gnt_r      <= 2'b00;
      rvalid_r   <= 2'b00;
      err_r      <= 2'b00;
      m0_rdata_r <= 32'h0000_0000;
      m1_rdata_r <= 32'h0000_0000;
      mem_w_r    <= 1'b0;
      mem_r_r    <= 1'b0;
      if (start_s) begin
        gnt_r[win_s] <= 1'b1;
        mem_addr_r   <= sel_addr_s;
        mem_wdata_r  <= sel_wdata_s;
        mem_w_r      <= sel_ok_s & sel_we_s;
        mem_r_r      <= sel_ok_s & ~sel_we_s;
      end else if (state_r == ACCESS) begin
        rvalid_r[id_r] <= 1'b1;
        err_r[id_r]    <= ~ok_r;
        if (id_r == M1) begin
          m1_rdata_r <= (ok_r && !we_r) ? mem_rdata : 32'h0000_0000;
        end else begin
          m0_rdata_r <= (ok_r && !we_r) ? mem_rdata : 32'h0000_0000;
        end
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign m0_gnt    = gnt_r[0];
  assign m1_gnt    = gnt_r[1];
  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];
  assign m0_err    = err_r[0];
  assign m1_err    = err_r[1];
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_w     = mem_w_r;
  assign mem_r     = mem_r_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_dm_arbiter;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_w, mem_r;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_r(mem_r),
    .mem_rdata(mem_rdata)
  );

  // Environment memory seen by the DUT (asynchronous read, write on the edge).
  bit          mem_init;
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (mem_w) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  // Reference model: expected outputs for the cycle after the coming edge.
  logic [31:0] ref_mem [DEPTH];
  int          busy;
  logic        last;
  logic [1:0]  exp_gnt, exp_rvalid, exp_err;
  logic [31:0] exp_rdata [2];
  logic        exp_mem_w, exp_mem_r;
  logic [31:0] exp_mem_addr, exp_mem_wdata;
  logic        pend_valid, pend_id, pend_err;
  logic [31:0] pend_rdata;

  task automatic model_edge();
    logic        w, we, ok;
    logic [31:0] a, d;
    exp_gnt = 2'b00; exp_rvalid = 2'b00; exp_err = 2'b00;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
    exp_mem_w = 1'b0; exp_mem_r = 1'b0;
    if (!rst_n) begin
      busy = 0; last = 1'b1; pend_valid = 1'b0;
      exp_mem_addr = 32'h0; exp_mem_wdata = 32'h0;
    end else begin
      if (pend_valid) begin
        exp_rvalid[pend_id] = 1'b1;
        exp_err[pend_id]    = pend_err;
        exp_rdata[pend_id]  = pend_rdata;
        pend_valid = 1'b0;
      end
      if (busy > 0) begin
        busy = busy - 1;
      end else if (m0_req || m1_req) begin
        if (m0_req && m1_req) w = ~last;
        else w = m1_req;
        we = w ? m1_we : m0_we;
        a  = w ? m1_addr : m0_addr;
        d  = w ? m1_wdata : m0_wdata;
        ok = (a < 32'(4 * DEPTH)) && (a % 4 == 0);
        exp_gnt[w] = 1'b1;
        exp_mem_addr = a; exp_mem_wdata = d;
        exp_mem_w = ok && we; exp_mem_r = ok && !we;
        pend_valid = 1'b1; pend_id = w; pend_err = !ok;
        pend_rdata = (ok && !we) ? ref_mem[a / 4] : 32'h0;
        if (ok && we) ref_mem[a / 4] = d;
        last = w;
        busy = 2;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    n_total++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err, mem_w, mem_r} !== 8'h00)
      $display("FAIL reset_ctrl: got %b required 00000000",
               {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err, mem_w, mem_r});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0)
      $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, m0_rdata, m1_rdata});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    cycle();
    n_total++;
    if ({m0_gnt, m1_gnt, mem_w, mem_r, mem_addr, mem_wdata} !== {4'b1010, 32'h10, 32'hDEADBEEF})
      $display("FAIL wr_access: got %b %b %b %b %h %h required 1 0 1 0 00000010 deadbeef",
               m0_gnt, m1_gnt, mem_w, mem_r, mem_addr, mem_wdata);
    else n_pass++;
    m0_req = 1'b0;
    cycle();
    n_total++;
    if ({m0_rvalid, m0_err, m0_gnt, mem_w, m0_rdata} !== {4'b1000, 32'h0})
      $display("FAIL wr_resp: got rvalid=%b err=%b gnt=%b mem_w=%b rdata=%h",
               m0_rvalid, m0_err, m0_gnt, mem_w, m0_rdata);
    else n_pass++;
    cycle();
    m0_req = 1'b1; m0_we = 1'b0;
    cycle();
    n_total++;
    if ({m0_gnt, mem_w, mem_r, mem_addr} !== {3'b101, 32'h10})
      $display("FAIL rd_access: got gnt=%b w=%b r=%b addr=%h required 1 0 1 00000010",
               m0_gnt, mem_w, mem_r, mem_addr);
    else n_pass++;
    m0_req = 1'b0;
    cycle();
    n_total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'hDEADBEEF})
      $display("FAIL rd_resp: got rvalid=%b err=%b rdata=%h required 1 0 deadbeef",
               m0_rvalid, m0_err, m0_rdata);
    else n_pass++;
    cycle();
  endtask

  task automatic test_tie();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_total++;
      if ({m0_gnt, m1_gnt} !== {(i == 0 || i == 6), (i == 3)})
        $display("FAIL tie_gnt[%0d]: got m0=%b m1=%b required m0=%b m1=%b",
                 i, m0_gnt, m1_gnt, (i == 0 || i == 6), (i == 3));
      else n_pass++;
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_out_of_range();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h400;
    cycle();
    n_total++;
    if ({m1_gnt, m0_gnt, mem_r, mem_w} !== 4'b1000)
      $display("FAIL oob_access: got gnt=%b/%b r=%b w=%b required 1/0 0 0",
               m1_gnt, m0_gnt, mem_r, mem_w);
    else n_pass++;
    m1_req = 1'b0;
    cycle();
    n_total++;
    if ({m1_rvalid, m1_err, m0_rvalid, m1_rdata} !== {3'b110, 32'h0})
      $display("FAIL oob_resp: got rvalid=%b err=%b m0_rvalid=%b rdata=%h",
               m1_rvalid, m1_err, m0_rvalid, m1_rdata);
    else n_pass++;
    cycle();
  endtask

  task automatic test_misaligned();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h6; m0_wdata = 32'h1234_5678;
    cycle();
    n_total++;
    if ({m0_gnt, mem_w, mem_r} !== 3'b100)
      $display("FAIL mis_access: got gnt=%b w=%b r=%b required 1 0 0", m0_gnt, mem_w, mem_r);
    else n_pass++;
    m0_req = 1'b0;
    cycle();
    n_total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== {2'b11, 32'h0})
      $display("FAIL mis_resp: got rvalid=%b err=%b rdata=%h required 1 1 0",
               m0_rvalid, m0_err, m0_rdata);
    else n_pass++;
    cycle();
  endtask

  task automatic test_reset_abort();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    cycle();
    n_total++;
    if (m1_gnt !== 1'b1) $display("FAIL abort_gnt: got %b required 1", m1_gnt);
    else n_pass++;
    m1_req = 1'b0;
    rst_n = 1'b0;
    cycle();
    n_total++;
    if ({m1_rvalid, m1_err, mem_r, mem_w} !== 4'b0000)
      $display("FAIL abort_reset: got rvalid=%b err=%b r=%b w=%b required 0 0 0 0",
               m1_rvalid, m1_err, mem_r, mem_w);
    else n_pass++;
    rst_n = 1'b1;
    cycle();
    n_total++;
    if (m1_rvalid !== 1'b0) $display("FAIL abort_norvalid: got %b required 0", m1_rvalid);
    else n_pass++;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    cycle();
    n_total++;
    if ({m0_gnt, mem_r} !== 2'b11) $display("FAIL abort_next_gnt: got gnt=%b r=%b required 1 1", m0_gnt, mem_r);
    else n_pass++;
    m0_req = 1'b0;
    cycle();
    n_total++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL abort_next_resp: got rvalid=%b rdata=%h required 1 deadbeef", m0_rvalid, m0_rdata);
    else n_pass++;
    cycle();
  endtask

  task automatic test_back_to_back();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_total++;
      if ({m1_gnt, m1_rvalid} !== {(i % 3 == 0), (i % 3 == 1)})
        $display("FAIL b2b[%0d]: got gnt=%b rvalid=%b required %b %b",
                 i, m1_gnt, m1_rvalid, (i % 3 == 0), (i % 3 == 1));
      else n_pass++;
    end
    idle_inputs();
    cycle();
    cycle();
  endtask

  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h400 + 32'($urandom_range(0, 1023));
    if (k == 1) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, 15)) * 4;
  endfunction

  task automatic test_random();
    logic        pend [2];
    logic        we_v [2];
    logic [31:0] a_v [2];
    logic [31:0] d_v [2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1;
          we_v[m] = 1'($urandom_range(0, 1));
          a_v[m]  = pick_addr();
          d_v[m]  = $urandom;
        end
      end
      m0_req = pend[0]; m0_we = we_v[0]; m0_addr = a_v[0]; m0_wdata = d_v[0];
      m1_req = pend[1]; m1_we = we_v[1]; m1_addr = a_v[1]; m1_wdata = d_v[1];
      cycle();
      n_total++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err} !== {exp_gnt, exp_rvalid, exp_err})
        $display("FAIL rnd_ctrl[%0d]: got %b required %b", n,
                 {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err}, {exp_gnt, exp_rvalid, exp_err});
      else n_pass++;
      n_total++;
      if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]})
        $display("FAIL rnd_rdata[%0d]: got %h/%h required %h/%h", n,
                 m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      else n_pass++;
      n_total++;
      if ({mem_w, mem_r, mem_addr, mem_wdata} !== {exp_mem_w, exp_mem_r, exp_mem_addr, exp_mem_wdata})
        $display("FAIL rnd_mem[%0d]: got w=%b r=%b a=%h d=%h required w=%b r=%b a=%h d=%h", n,
                 mem_w, mem_r, mem_addr, mem_wdata, exp_mem_w, exp_mem_r, exp_mem_addr, exp_mem_wdata);
      else n_pass++;
      for (int m = 0; m < 2; m++) if (exp_gnt[m]) pend[m] = 1'b0;
    end
    idle_inputs();
    rst_n = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h5A00_0000 | 32'(i);
    busy = 0; last = 1'b1; pend_valid = 1'b0;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_tie();
    test_out_of_range();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
